bcd_scan_display: RTL and testbench

//  Multi-digit 7-segment driver. Converts an unsigned binary value to BCD with a

---
 rtl/bcd_scan_display.sv | 172 +++++++++++++++++
 tb/tb_bcd_scan_display.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_display.sv
// Binary -> BCD via sequential double dabble, shown on a multiplexed common-anode 7-segment bus.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant nonzero one.
module bcd_scan_display #(
  parameter int DIGITS  = 4,
  parameter int BIN_W   = 14,
  parameter int CLK_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BIN_W-1:0]  bin,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + BIN_W;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t             state_q;
  logic [SH_W-1:0]    sh_q;
  logic [SH_W-1:0]    sh_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_pend_q;
  logic               busy_q, done_q, ovf_q;
  logic [BCD_W-1:0]   store_q;

  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [6:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  an_q, an_d;
  logic [3:0]         digit;

  // One double-dabble step: adjust BCD nibbles, then shift the whole register left.
  always_comb begin
    sh_d = sh_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (sh_d[BIN_W + 4*i +: 4] >= 4'd5)
        sh_d[BIN_W + 4*i +: 4] = sh_d[BIN_W + 4*i +: 4] + 4'd3;
    end
    sh_d = {sh_d[SH_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      store_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            sh_q       <= {{BCD_W{1'b0}}, bin};
            cnt_q      <= '0;
            ovf_pend_q <= (64'(bin) > MAX_VAL);
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= COMMIT;
        end
        COMMIT: begin
          store_q <= sh_q[SH_W-1 -: BCD_W];
          ovf_q   <= ovf_pend_q;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] keep;

  // A digit is kept if it or any more significant digit is nonzero; digit 0 always kept.
  always_comb begin
    logic seen;
    seen = 1'b0;
    keep = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (store_q[4*i +: 4] != 4'd0);
      keep[i] = seen | (i == 0);
    end
  end
`endif

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    an_d        = '1;
    an_d[idx_q] = 1'b0;

    digit = store_q[{idx_q, 2'b00} +: 4];
    if (ovf_q) seg_d = SEG_DASH;
`ifdef LEADING_ZERO_BLANK_EN
    else if (!keep[idx_q]) seg_d = SEG_BLANK;
`endif
    else seg_d = seg_code(digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display (DIGITS=4, BIN_W=14, CLK_DIV=4); honours LEADING_ZERO_BLANK_EN.
module tb_bcd_scan_display;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S7 = 7'b0001111, S9 = 7'b0000100,
                         BLK = 7'b1111111, DSH = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] bin;
  logic        load;
  logic        busy, done, ovf;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_scan_display #(.DIGITS(4), .BIN_W(14), .CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bin(bin), .load(load),
    .busy(busy), .done(done), .ovf(ovf), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Watch one full scan period and compare the segment code for each enabled digit.
  task automatic show_check(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] exp_seg [4];
    logic [3:0] seen;
    int         zeros;
    exp_seg[0] = e0; exp_seg[1] = e1; exp_seg[2] = e2; exp_seg[3] = e3;
    seen = 4'b0000;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      zeros = 0;
      for (int d = 0; d < 4; d++) if (!an[d]) zeros++;
      check({tag, "_onehot"}, 32'(zeros), 32'd1);
      for (int d = 0; d < 4; d++) begin
        if (!an[d]) begin
          seen[d] = 1'b1;
          check($sformatf("%s_d%0d", tag, d), 32'(seg), 32'(exp_seg[d]));
        end
      end
    end
    check({tag, "_all_digits"}, 32'(seen), 32'hF);
  endtask

  // Called at a negedge; pulses load for one cycle and watches busy/done for 40 cycles.
  task automatic do_load(input logic [13:0] v, output int nb, output int nd, output int bad_done);
    logic prev_busy;
    bin = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    nb = 0; nd = 0; bad_done = 0; prev_busy = 1'b1;
    repeat (40) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        if (busy || !prev_busy) bad_done++;
      end
      prev_busy = busy;
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, nd, bad;
    logic [3:0] ea;
    rst_n = 1'b1; load = 1'b0; bin = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_seg",  32'(seg),  32'h7F);
    check("rst_an",   32'(an),   32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);

    // Scan timing: each digit held for 4 cycles starting from digit 0.
    rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      ea = 4'hF;
      ea[((n - 1) / 4) % 4] = 1'b0;
      check($sformatf("scan_an_c%0d", n), 32'(an), 32'(ea));
      check($sformatf("scan_seg_c%0d", n), 32'(seg), 32'(S0));
    end

    do_load(14'd1234, nb, nd, bad);
    check("l1234_busy_cycles", 32'(nb), 32'd15);
    check("l1234_done_pulses", 32'(nd), 32'd1);
    check("l1234_done_timing", 32'(bad), 32'd0);
    check("l1234_ovf", 32'(ovf), 32'd0);
    show_check("l1234", S1, S2, S3, S4);

    do_load(14'd9999, nb, nd, bad);
    check("l9999_ovf", 32'(ovf), 32'd0);
    show_check("l9999", S9, S9, S9, S9);

    do_load(14'd10000, nb, nd, bad);
    check("l10000_ovf", 32'(ovf), 32'd1);
    check("l10000_done_pulses", 32'(nd), 32'd1);
    show_check("l10000", DSH, DSH, DSH, DSH);

    // Second load while busy must be ignored.
    bin = 14'd42; load = 1'b1;
    @(negedge clk);
    bin = 14'd7;
    repeat (5) @(negedge clk);
    load = 1'b0;
    nd = 0;
    repeat (30) begin
      if (done) nd++;
      @(negedge clk);
    end
    check("l42_done_pulses", 32'(nd), 32'd1);
    check("l42_ovf", 32'(ovf), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
    show_check("l42", BLK, BLK, S4, S2);
`else
    show_check("l42", S0, S0, S4, S2);
`endif

    // Bring ovf high again so the mid-conversion reset has something to clear.
    do_load(14'd10000, nb, nd, bad);
    check("pre_rst_ovf", 32'(ovf), 32'd1);

    bin = 14'd5678; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_shift_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_seg",  32'(seg),  32'h7F);
    check("arst_an",   32'(an),   32'hF);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0; nd = 0;
    repeat (30) begin
      if (busy) nb++;
      if (done) nd++;
      @(negedge clk);
    end
    check("arst_no_busy", 32'(nb), 32'd0);
    check("arst_no_done", 32'(nd), 32'd0);
`ifdef LEADING_ZERO_BLANK_EN
    show_check("arst_disp", BLK, BLK, BLK, S0);
`else
    show_check("arst_disp", S0, S0, S0, S0);
`endif

    do_load(14'd5, nb, nd, bad);
`ifdef LEADING_ZERO_BLANK_EN
    show_check("l5", BLK, BLK, BLK, S5);
`else
    show_check("l5", S0, S0, S0, S5);
`endif

    do_load(14'd7, nb, nd, bad);
    check("l7_busy_cycles", 32'(nb), 32'd15);
`ifdef LEADING_ZERO_BLANK_EN
    show_check("l7", BLK, BLK, BLK, S7);
`else
    show_check("l7", S0, S0, S0, S7);
`endif

    do_load(14'd0, nb, nd, bad);
    check("l0_done_pulses", 32'(nd), 32'd1);
`ifdef LEADING_ZERO_BLANK_EN
    show_check("l0", BLK, BLK, BLK, S0);
`else
    show_check("l0", S0, S0, S0, S0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
